// File: rtl/led_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_panel_pkg
// Description : Shared definitions for the LED panel scan sequencer: scan
//               state enumeration, default geometry/timing constants, the
//               on-time counter width and the BCM on-time helper.
// Revision    : 1.0 - initial release
// ============================================================================
package led_panel_pkg;

  // Default geometry and timing
  localparam int COLS_DEFAULT    = 64;
  localparam int ROWS_DEFAULT    = 16;
  localparam int PLANES_DEFAULT  = 3;
  localparam int ON_BASE_DEFAULT = 8;

  // 255 << 3 needs 11 bits; one spare bit keeps the counter clear of overflow
  localparam int ON_CNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DISPLAY  = 3'd4
  } scan_state_t;

  // Binary-code modulation: plane n is lit for base * 2^n cycles
  function automatic logic [ON_CNT_W-1:0] on_time(input int unsigned base,
                                                  input logic [1:0]    pl);
    return ON_CNT_W'(base) << pl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : On-time down-counter for the DISPLAY phase. A load sets the
//               count; the counter then decrements to zero and stays there.
//               done is high for exactly one cycle, the last lit cycle.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset
//               load     - load load_val into the counter
//               load_val - on-time in cycles (never zero)
//               done     - one-cycle pulse on the final counted cycle
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer
  import led_panel_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ON_CNT_W-1:0] load_val,
  output logic                done
);

  logic [ON_CNT_W-1:0] cnt_q;
  logic [ON_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ON_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count equals the remaining lit cycles including the current one,
  // so a value of one marks the last of them.
  assign done = (cnt_q == ON_CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/panel_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : panel_scan_sequencer
// Description : HUB75-style LED panel scan sequencer. For each (row, plane)
//               it shifts COLS columns out (two cycles per column), latches
//               them, then lights the row for ON_BASE << plane cycles.
//               All outputs are registered.
// Config      : PANEL_SCAN_BCM_EN defined   - binary-code modulation over
//                                             PLANES bit planes
//               PANEL_SCAN_BCM_EN undefined - single plane (plane held at 0),
//                                             every row lit ON_BASE cycles
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               enable     - run request, sampled in IDLE and at DISPLAY end
//               x          - column address to the frame buffer
//               y          - row address to the frame buffer
//               plane      - bit-plane index to the frame buffer
//               led_clk    - panel shift clock
//               led_latch  - panel latch strobe, active-high
//               led_oe     - panel output enable, active-low
//               dmux       - displayed row select
//               frame_done - one-cycle pulse after the last row/plane
//               busy       - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module panel_scan_sequencer
  import led_panel_pkg::*;
#(
  parameter int COLS    = COLS_DEFAULT,
  parameter int ROWS    = ROWS_DEFAULT,
  parameter int PLANES  = PLANES_DEFAULT,
  parameter int ON_BASE = ON_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [5:0] x,
  output logic [3:0] y,
  output logic [1:0] plane,
  output logic       led_clk,
  output logic       led_latch,
  output logic       led_oe,
  output logic [3:0] dmux,
  output logic       frame_done,
  output logic       busy
);

`ifdef PANEL_SCAN_BCM_EN
  localparam int PLANES_EFF = PLANES;
`else
  // Single-plane build: clamp to one plane whatever PLANES says
  localparam int PLANES_EFF = (PLANES > 1) ? 1 : PLANES;
`endif

  localparam logic [5:0] X_LAST = 6'(COLS - 1);
  localparam logic [3:0] Y_LAST = 4'(ROWS - 1);
  localparam logic [1:0] P_LAST = 2'(PLANES_EFF - 1);

  scan_state_t state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic [1:0]  plane_q, plane_d;
  logic [3:0]  dmux_q, dmux_d;
  logic        led_clk_q, led_clk_d;
  logic        led_latch_q, led_latch_d;
  logic        led_oe_q, led_oe_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;

  logic        timer_load;
  logic        timer_done;

  scan_timer u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (on_time(ON_BASE, plane_q)),
    .done     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    plane_d      = plane_q;
    dmux_d       = dmux_q;
    frame_done_d = 1'b0;
    timer_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_LO: begin
        state_d = ST_SHIFT_HI;
      end

      ST_SHIFT_HI: begin
        if (x_q == X_LAST) begin
          x_d     = '0;
          // Row select moves with the latch so the new data and its row
          // appear together while the panel is still blanked.
          dmux_d  = y_q;
          state_d = ST_LATCH;
        end else begin
          x_d     = x_q + 6'd1;
          state_d = ST_SHIFT_LO;
        end
      end

      ST_LATCH: begin
        // Loading here makes the count valid on the first DISPLAY cycle.
        timer_load = 1'b1;
        state_d    = ST_DISPLAY;
      end

      ST_DISPLAY: begin
        if (timer_done) begin
          // Advance before the next shift so the shifted data belongs to
          // the (y, plane) that is displayed next.
          if (plane_q == P_LAST) begin
            plane_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
            end else begin
              y_d = y_q + 4'd1;
            end
          end else begin
            plane_d = plane_q + 2'd1;
          end
          state_d = enable ? ST_SHIFT_LO : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Panel strobes are decoded from the next state so they line up with
    // the state register.
    led_clk_d   = (state_d == ST_SHIFT_HI);
    led_latch_d = (state_d == ST_LATCH);
    led_oe_d    = (state_d != ST_DISPLAY);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      plane_q      <= '0;
      dmux_q       <= '0;
      led_clk_q    <= 1'b0;
      led_latch_q  <= 1'b0;
      led_oe_q     <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      plane_q      <= plane_d;
      dmux_q       <= dmux_d;
      led_clk_q    <= led_clk_d;
      led_latch_q  <= led_latch_d;
      led_oe_q     <= led_oe_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign plane      = plane_q;
  assign dmux       = dmux_q;
  assign led_clk    = led_clk_q;
  assign led_latch  = led_latch_q;
  assign led_oe     = led_oe_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_panel_scan_sequencer
// Description : Directed self-checking bench for panel_scan_sequencer with
//               COLS=4, ROWS=2, PLANES=2, ON_BASE=2. Expected cycle numbers
//               are counted from the first SHIFT_LO cycle after enable.
//               Follows PANEL_SCAN_BCM_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [5:0] x;
  logic [3:0] y;
  logic [1:0] plane;
  logic       led_clk;
  logic       led_latch;
  logic       led_oe;
  logic [3:0] dmux;
  logic       frame_done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle trace of the outputs
  logic [5:0] tx    [0:127];
  logic [3:0] ty    [0:127];
  logic [1:0] tpl   [0:127];
  logic       tclk  [0:127];
  logic       tlat  [0:127];
  logic       toe   [0:127];
  logic [3:0] tdmux [0:127];
  logic       tfd   [0:127];
  logic       tbusy [0:127];

  panel_scan_sequencer #(
    .COLS    (4),
    .ROWS    (2),
    .PLANES  (2),
    .ON_BASE (2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .x          (x),
    .y          (y),
    .plane      (plane),
    .led_clk    (led_clk),
    .led_latch  (led_latch),
    .led_oe     (led_oe),
    .dmux       (dmux),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int i);
    tx[i]    = x;
    ty[i]    = y;
    tpl[i]   = plane;
    tclk[i]  = led_clk;
    tlat[i]  = led_latch;
    toe[i]   = led_oe;
    tdmux[i] = dmux;
    tfd[i]   = frame_done;
    tbusy[i] = busy;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_x"},     32'(x),          32'd0);
    check({pfx, "_y"},     32'(y),          32'd0);
    check({pfx, "_plane"}, 32'(plane),      32'd0);
    check({pfx, "_dmux"},  32'(dmux),       32'd0);
    check({pfx, "_clk"},   32'(led_clk),    32'd0);
    check({pfx, "_latch"}, 32'(led_latch),  32'd0);
    check({pfx, "_oe"},    32'(led_oe),     32'd1);
    check({pfx, "_fd"},    32'(frame_done), 32'd0);
    check({pfx, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    int cnt;
    int bad;

    // ---------------- reset state ----------------
    rst    = 1'b1;
    enable = 1'b0;
    step;
    step;
    check_reset("rst");

    // ---------------- free run, enable held high ----------------
    rst    = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step;
      rec(c);
    end

    check("run_busy0",   32'(tbusy[0]), 32'd1);
    check("run_clk0",    32'(tclk[0]),  32'd0);
    check("run_x0",      32'(tx[0]),    32'd0);
    check("run_clk1",    32'(tclk[1]),  32'd1);
    check("run_x2",      32'(tx[2]),    32'd1);
    check("run_x7",      32'(tx[7]),    32'd3);
    check("run_lat8",    32'(tlat[8]),  32'd1);
    check("run_oe8",     32'(toe[8]),   32'd1);
    check("run_dmux8",   32'(tdmux[8]), 32'd0);
    check("run_oe9",     32'(toe[9]),   32'd0);
    check("run_oe10",    32'(toe[10]),  32'd0);
    check("run_oe11",    32'(toe[11]),  32'd1);
    check("run_x11",     32'(tx[11]),   32'd0);

    cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      if (tclk[c] && (c == 0 || !tclk[c-1])) cnt++;
    end
    check("run_clk_edges_row0", 32'(cnt), 32'd4);

    cnt = 0;
    for (int c = 0; c <= 10; c++) if (tlat[c]) cnt++;
    check("run_latches_row0", 32'(cnt), 32'd1);

    bad = 0;
    for (int c = 0; c < 100; c++) if (tlat[c] && !toe[c]) bad++;
    check("run_latch_while_lit", 32'(bad), 32'd0);

    cnt = 0;
    for (int c = 0; c < 100; c++) if (tfd[c]) cnt++;

`ifdef PANEL_SCAN_BCM_EN
    check("bcm_plane11",  32'(tpl[11]),  32'd1);
    check("bcm_lat19",    32'(tlat[19]), 32'd1);
    bad = 0;
    for (int c = 11; c <= 23; c++) if (!toe[c]) bad++;
    check("bcm_oe_low_p1", 32'(bad), 32'd4);
    check("bcm_oe24",     32'(toe[24]),  32'd1);
    check("bcm_y24",      32'(ty[24]),   32'd1);
    check("bcm_plane24",  32'(tpl[24]),  32'd0);
    check("bcm_lat32",    32'(tlat[32]), 32'd1);
    check("bcm_dmux32",   32'(tdmux[32]), 32'd1);
    check("bcm_fd47",     32'(tfd[47]),  32'd0);
    check("bcm_y47",      32'(ty[47]),   32'd1);
    check("bcm_fd48",     32'(tfd[48]),  32'd1);
    check("bcm_y48",      32'(ty[48]),   32'd0);
    check("bcm_fd96",     32'(tfd[96]),  32'd1);
    check("bcm_fd_count", 32'(cnt),      32'd2);
`else
    bad = 0;
    for (int c = 0; c < 100; c++) if (tpl[c] != 2'd0) bad++;
    check("single_plane_nonzero", 32'(bad), 32'd0);
    check("single_y11",     32'(ty[11]),   32'd1);
    check("single_lat19",   32'(tlat[19]), 32'd1);
    check("single_dmux19",  32'(tdmux[19]), 32'd1);
    check("single_fd21",    32'(tfd[21]),  32'd0);
    check("single_fd22",    32'(tfd[22]),  32'd1);
    check("single_y22",     32'(ty[22]),   32'd0);
    check("single_fd44",    32'(tfd[44]),  32'd1);
    check("single_fd_count", 32'(cnt),     32'd4);
`endif

    // ---------------- enable dropped during the second shift ----------------
    rst    = 1'b1;
    enable = 1'b0;
    step;
    rst    = 1'b0;
    enable = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      step;
      rec(c);
    end
    check("drop_clk12", 32'(tclk[12]), 32'd1);
    enable = 1'b0;
    for (int c = 13; c <= 29; c++) begin
      step;
      rec(c);
    end
    check("drop_lat19", 32'(tlat[19]), 32'd1);
`ifdef PANEL_SCAN_BCM_EN
    bad = 0;
    for (int c = 20; c <= 23; c++) if (!toe[c]) bad++;
    check("drop_oe_low", 32'(bad), 32'd4);
    check("drop_oe24",   32'(toe[24]),   32'd1);
    check("drop_busy24", 32'(tbusy[24]), 32'd0);
    check("drop_y24",    32'(ty[24]),    32'd1);
`else
    check("drop_oe21",   32'(toe[21]),   32'd0);
    check("drop_oe22",   32'(toe[22]),   32'd1);
    check("drop_busy22", 32'(tbusy[22]), 32'd0);
    check("drop_fd22",   32'(tfd[22]),   32'd1);
    check("drop_y22",    32'(ty[22]),    32'd0);
`endif
    check("drop_busy29", 32'(tbusy[29]), 32'd0);
    check("drop_oe29",   32'(toe[29]),   32'd1);

    enable = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      step;
      rec(c);
    end
    check("resume_busy0", 32'(tbusy[0]), 32'd1);
    check("resume_lat8",  32'(tlat[8]),  32'd1);
`ifdef PANEL_SCAN_BCM_EN
    check("resume_dmux8", 32'(tdmux[8]), 32'd1);
`else
    check("resume_dmux8", 32'(tdmux[8]), 32'd0);
`endif

    // ---------------- reset in the middle of DISPLAY ----------------
    rst    = 1'b1;
    enable = 1'b0;
    step;
    rst    = 1'b0;
    enable = 1'b1;
`ifdef PANEL_SCAN_BCM_EN
    // Plane 1 display covers cycles 20..23; reset lands in cycle 22
    for (int c = 0; c <= 21; c++) begin
      step;
      rec(c);
    end
    check("midrst_oe21", 32'(toe[21]), 32'd0);
`else
    // Row 0 display covers cycles 9..10; reset lands in cycle 10
    for (int c = 0; c <= 9; c++) begin
      step;
      rec(c);
    end
    check("midrst_oe9", 32'(toe[9]), 32'd0);
`endif
    rst = 1'b1;
    step;
    check_reset("midrst");
    step;
    check("midrst_hold_busy", 32'(busy), 32'd0);
    rst    = 1'b0;
    enable = 1'b0;
    step;
    check("midrst_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/panel_scan_sequencer.md
PANEL_SCAN_SEQUENCER -- requirements
Module: panel_scan_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 64: columns shifted per row; range 2..64.
REQ-002 SHALL have parameter ROWS, default 16: row pairs scanned; range 2..16.
REQ-003 SHALL have parameter PLANES, default 3: bit planes per row; range 1..4.
REQ-004 SHALL have parameter ON_BASE, default 8: display cycles for plane 0; range 1..255.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable, input, 1: run request.
REQ-008 SHALL have port x, output, 6: column address to the frame buffer.
REQ-009 SHALL have port y, output, 4: row address to the frame buffer.
REQ-010 SHALL have port plane, output, 2: bit-plane index to the frame buffer.
REQ-011 SHALL have port led_clk, output, 1: panel shift clock.
REQ-012 SHALL have port led_latch, output, 1: panel latch strobe, active-high.
REQ-013 SHALL have port led_oe, output, 1: panel output enable, active-low (1 = blanked).
REQ-014 SHALL have port dmux, output, 4: displayed row select.
REQ-015 SHALL have port frame_done, output, 1: one-cycle pulse at the end of each frame.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY; all outputs registered.
REQ-018 IDLE: led_oe=1, led_clk=0, led_latch=0; enter SHIFT_LO on the cycle after enable is sampled high.
REQ-019 SHIFT_LO: led_clk=0, x presents the current column; next state SHIFT_HI.
REQ-020 SHIFT_HI: led_clk=1; if x=COLS-1, clear x and go to LATCH; otherwise increment x and go to SHIFT_LO. A shift takes exactly 2*COLS cycles.
REQ-021 LATCH: led_latch=1 for exactly one cycle, led_oe=1, dmux loaded with y in the same cycle; next state DISPLAY.
REQ-022 DISPLAY: led_oe=0 for exactly ON_BASE<<plane cycles; the on-time counter is at least 12 bits and never saturates.
REQ-023 End of DISPLAY: advance plane; on plane=PLANES-1, clear plane and advance y; on y=ROWS-1 as well, clear y and pulse frame_done for one cycle.
REQ-024 End of DISPLAY: go to SHIFT_LO if enable=1, otherwise go to IDLE with led_oe=1; enable is ignored in all other states, so a started plane always completes.
REQ-025 led_oe SHALL be 1 throughout SHIFT_LO, SHIFT_HI, LATCH and IDLE; dmux SHALL change only in LATCH.
REQ-026 The data shifted SHALL be for the (y, plane) that DISPLAY shows next.

Reset
REQ-027 rst SHALL override all other inputs, in any state including mid-shift or mid-DISPLAY.
REQ-028 On the cycle after rst is sampled high: state=IDLE, x=0, y=0, plane=0, dmux=0, led_clk=0, led_latch=0, led_oe=1, frame_done=0, busy=0.

Configuration
REQ-029 Macro PANEL_SCAN_BCM_EN defined: binary-code modulation over PLANES planes, as in REQ-022 and REQ-023.
REQ-030 Macro PANEL_SCAN_BCM_EN undefined: the effective plane count SHALL be 1, plane is held at 0, every DISPLAY lasts ON_BASE cycles, and y advances after every DISPLAY.

Structure
REQ-031 Package led_panel_pkg SHALL hold the state enumeration and the default constants COLS, ROWS, PLANES and ON_BASE.
REQ-032 The on-time down-counter SHALL be sub-module scan_timer, with load value ON_BASE<<plane and a one-cycle done output.

Verification
All scenarios use COLS=4, ROWS=2, PLANES=2 and ON_BASE=2 unless stated otherwise.
REQ-033 Reset, then enable held high -> 4 led_clk rising edges, 1 latch, led_oe low for 2 cycles, then 4 led_clk rising edges, 1 latch, led_oe low for 4 cycles; one row takes 24 cycles.
REQ-034 enable held high with PANEL_SCAN_BCM_EN defined -> frame_done pulses every 48 cycles; dmux sequence 0,1,0,...; the y wrap 1->0 coincides with frame_done.
REQ-035 Same stimulus with PANEL_SCAN_BCM_EN undefined -> row period 11 cycles, frame_done every 22 cycles, plane always 0.
REQ-036 enable dropped during SHIFT_HI of plane 1 -> that plane's 4-cycle DISPLAY completes, then IDLE with led_oe=1 and busy=0; re-enable resumes with y advanced by one.
REQ-037 rst asserted in the 3rd cycle of DISPLAY -> the next cycle shows led_oe=1 and all REQ-028 values; led_latch never asserts while led_oe=0 in any run.
